// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Byte FIFO plus launch sequencer sitting in front of the UART transmitter.
//   Producers push bytes; the sequencer pops one at a time, strobes it out on
//   data_ready/byte_trans, then waits for the transmitter's done_sig (plus one
//   gap cycle) before the next launch. After reset a holdoff period lets any
//   frame the (non-reset) transmitter is still sending run to completion.
//
// Ports
//   clk, rst       : clock, synchronous active-high reset
//   wr_en, wr_data : enqueue request and byte
//   clr_overflow   : clears the sticky overflow flag (a same-cycle drop wins)
//   full, empty    : occupancy flags derived from level
//   level          : occupancy 0..DEPTH
//   overflow       : sticky, set when a write hits a full FIFO
//   busy           : sequencer not idle (includes the post-reset holdoff)
//   data_ready     : one-cycle launch strobe to the transmitter
//   byte_trans     : byte to the transmitter, stable until the next pop
//   done_sig       : transmitter frame-complete pulse, honoured only in WAIT
module uart_tx_fifo #(
    parameter int DEPTH          = 16,
    parameter int HOLDOFF_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     clr_overflow,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     busy,
    output logic                     data_ready,
    output logic [7:0]               byte_trans,
    input  logic                     done_sig
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_GAP
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   hold_cnt;

    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    logic            wr_ok;
    logic            drop;
    logic            pop;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

    // full is taken from the registered level, so a write while full is
    // dropped even when a pop lands on the same edge.
    always_comb begin
        wr_ok     = wr_en && !full;
        drop      = wr_en && full;
        pop       = (state == ST_IDLE) && !empty;
        busy      = (state != ST_IDLE);
        state_nxt = state;
        case (state)
            ST_HOLD: if (hold_cnt == '0) state_nxt = ST_IDLE;
            ST_IDLE: if (!empty)         state_nxt = ST_SEND;
            ST_SEND:                     state_nxt = ST_WAIT;
            ST_WAIT: if (done_sig)       state_nxt = ST_GAP;
            ST_GAP:                      state_nxt = ST_IDLE;
            default:                     state_nxt = ST_HOLD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_HOLD;
            hold_cnt <= CW'(HOLDOFF_CYCLES - 1);
        end else begin
            state <= state_nxt;
            if (state == ST_HOLD && hold_cnt != '0)
                hold_cnt <= hold_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow   <= 1'b0;
            data_ready <= 1'b0;
            byte_trans <= '0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                byte_trans <= mem[rd_ptr];
            end
            data_ready <= pop;
            level      <= level + LW'(wr_ok) - LW'(pop);
            if (drop)
                overflow <= 1'b1;
            else if (clr_overflow)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_ok)
            mem[wr_ptr] <= wr_data;
    end

endmodule
